// File: rtl/msrv32_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, funct3 operation codes,
// status/interrupt bit positions and trap cause codes.
package msrv32_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // funct3 encodings; bit 2 selects the zero-extended immediate source
    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;
    localparam int unsigned CSR_OP_IMM_BIT = 2;

    typedef enum logic [1:0] {
        CSR_KIND_NONE = 2'b00,
        CSR_KIND_RW   = 2'b01,
        CSR_KIND_RS   = 2'b10,
        CSR_KIND_RC   = 2'b11
    } csr_kind_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MSIE_BIT     = 3;
    localparam int unsigned MIP_MEIP_BIT     = 11;
    localparam int unsigned MIP_MTIP_BIT     = 7;
    localparam int unsigned MIP_MSIP_BIT     = 3;

    localparam logic [3:0] CAUSE_INSTR_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT            = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M               = 4'd11;
    localparam logic [3:0] CAUSE_M_SOFTWARE_IRQ        = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ           = 4'd7;
    localparam logic [3:0] CAUSE_M_EXTERNAL_IRQ        = 4'd11;

    // Read-only CSRs: the user counter mirrors (addr[11:10] == 2'b11), misa and mip
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MISA) || (addr == CSR_MIP);
    endfunction

endpackage

// File: rtl/msrv32_csr_counter.sv
// 64-bit machine counter with independently writable halves; a write to
// either half replaces it and holds off the increment for that cycle.
module msrv32_csr_counter
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        inc_en,
    input  logic        wr_lo_en,
    input  logic        wr_hi_en,
    input  logic [31:0] wr_data,
    output logic [63:0] count_out
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            count_out <= '0;
        end else if (wr_lo_en) begin
            count_out[31:0] <= wr_data;
        end else if (wr_hi_en) begin
            count_out[63:32] <= wr_data;
        end else if (inc_en) begin
            count_out <= count_out + 64'd1;
        end
    end

endmodule

// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file: read mux, funct3 read-modify-write, trap state
// updates, interrupt pending capture and the mcycle/minstret counters.
module msrv32_csr_file
    import msrv32_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
)
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        wr_en_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  zimm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iadder_in,
    input  logic        set_epc_in,
    input  logic        set_cause_in,
    input  logic        i_or_e_in,
    input  logic [3:0]  cause_in,
    input  logic        instret_inc_in,
    input  logic        mie_clear_in,
    input  logic        mie_set_in,
    input  logic        misaligned_exception_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    output logic [31:0] csr_data_out,
    output logic [31:0] epc_out,
    output logic [31:0] trap_address_out,
    output logic        mie_out,
    output logic        meie_out,
    output logic        mtie_out,
    output logic        msie_out,
    output logic        meip_out,
    output logic        mtip_out,
    output logic        msip_out,
    output logic        illegal_csr_out
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mie_msie;
    logic        mip_meip;
    logic        mip_mtip;
    logic        mip_msip;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        addr_hit;
    logic [31:0] wr_src;
    logic [31:0] wr_value;
    logic        wr_attempt;
    logic        wr_req;
    csr_kind_e   op_kind;

    assign op_kind = csr_kind_e'(csr_op_in[1:0]);
    assign wr_src  = csr_op_in[CSR_OP_IMM_BIT] ? {27'b0, zimm_in} : rs1_in;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the case can infer a latch.
    always_comb begin
        csr_data_out = '0;
        addr_hit     = 1'b1;
        case (csr_addr_in)
            CSR_MSTATUS: begin
                csr_data_out[12:11]            = 2'b11;
                csr_data_out[MSTATUS_MPIE_BIT] = mstatus_mpie;
                csr_data_out[MSTATUS_MIE_BIT]  = mstatus_mie;
            end
            CSR_MISA:     csr_data_out = MISA_VALUE;
            CSR_MIE: begin
                csr_data_out[MIE_MEIE_BIT] = mie_meie;
                csr_data_out[MIE_MTIE_BIT] = mie_mtie;
                csr_data_out[MIE_MSIE_BIT] = mie_msie;
            end
            CSR_MTVEC:    csr_data_out = mtvec;
            CSR_MSCRATCH: csr_data_out = mscratch;
            CSR_MEPC:     csr_data_out = mepc;
            CSR_MCAUSE:   csr_data_out = mcause;
            CSR_MTVAL:    csr_data_out = mtval;
            CSR_MIP: begin
                csr_data_out[MIP_MEIP_BIT] = mip_meip;
                csr_data_out[MIP_MTIP_BIT] = mip_mtip;
                csr_data_out[MIP_MSIP_BIT] = mip_msip;
            end
            CSR_MCYCLE, CSR_CYCLE:       csr_data_out = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     csr_data_out = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_data_out = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_data_out = minstret[63:32];
            default:      addr_hit = 1'b0;
        endcase
    end

    // Set/clear forms with a zero source are pure reads and never write
    always_comb begin
        wr_value   = csr_data_out;
        wr_attempt = 1'b0;
        case (op_kind)
            CSR_KIND_RW: begin
                wr_value   = wr_src;
                wr_attempt = 1'b1;
            end
            CSR_KIND_RS: begin
                wr_value   = csr_data_out | wr_src;
                wr_attempt = (wr_src != '0);
            end
            CSR_KIND_RC: begin
                wr_value   = csr_data_out & ~wr_src;
                wr_attempt = (wr_src != '0);
            end
            default: begin
                wr_value   = csr_data_out;
                wr_attempt = 1'b0;
            end
        endcase
    end

    assign illegal_csr_out = wr_en_in &&
                             (!addr_hit || (csr_is_read_only(csr_addr_in) && wr_attempt));
    assign wr_req          = wr_en_in && wr_attempt && !illegal_csr_out;

    // Trap-side updates are checked first so a same-cycle CSR write loses
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_msie     <= 1'b0;
            mip_meip     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_msip     <= 1'b0;
            mtvec        <= MTVEC_RESET & ~32'h2;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else begin
            mip_meip <= e_irq_in;
            mip_mtip <= t_irq_in;
            mip_msip <= s_irq_in;

            if (mie_clear_in) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mie_set_in) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr_req && csr_addr_in == CSR_MSTATUS) begin
                mstatus_mie  <= wr_value[MSTATUS_MIE_BIT];
                mstatus_mpie <= wr_value[MSTATUS_MPIE_BIT];
            end

            if (wr_req && csr_addr_in == CSR_MIE) begin
                mie_meie <= wr_value[MIE_MEIE_BIT];
                mie_mtie <= wr_value[MIE_MTIE_BIT];
                mie_msie <= wr_value[MIE_MSIE_BIT];
            end

            if (wr_req && csr_addr_in == CSR_MTVEC)
                mtvec <= wr_value & ~32'h2;

            if (wr_req && csr_addr_in == CSR_MSCRATCH)
                mscratch <= wr_value;

            if (set_epc_in)
                mepc <= pc_in & ~32'h3;
            else if (wr_req && csr_addr_in == CSR_MEPC)
                mepc <= wr_value & ~32'h3;

            if (set_cause_in) begin
                mcause <= {i_or_e_in, 27'b0, cause_in};
                mtval  <= misaligned_exception_in ? iadder_in : 32'h0;
            end else begin
                if (wr_req && csr_addr_in == CSR_MCAUSE)
                    mcause <= wr_value;
                if (wr_req && csr_addr_in == CSR_MTVAL)
                    mtval <= wr_value;
            end
        end
    end

    msrv32_csr_counter u_mcycle (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .inc_en               (1'b1),
        .wr_lo_en             (wr_req && csr_addr_in == CSR_MCYCLE),
        .wr_hi_en             (wr_req && csr_addr_in == CSR_MCYCLEH),
        .wr_data              (wr_value),
        .count_out            (mcycle)
    );

    msrv32_csr_counter u_minstret (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .inc_en               (instret_inc_in),
        .wr_lo_en             (wr_req && csr_addr_in == CSR_MINSTRET),
        .wr_hi_en             (wr_req && csr_addr_in == CSR_MINSTRETH),
        .wr_data              (wr_value),
        .count_out            (minstret)
    );

    // Vectored mode only offsets the base for interrupts
    always_comb begin
        trap_address_out = {mtvec[31:2], 2'b00};
        if (mtvec[0] && mcause[31])
            trap_address_out = {mtvec[31:2], 2'b00} + {26'b0, mcause[3:0], 2'b00};
    end

    assign epc_out  = mepc;
    assign mie_out  = mstatus_mie;
    assign meie_out = mie_meie;
    assign mtie_out = mie_mtie;
    assign msie_out = mie_msie;
    assign meip_out = mip_meip;
    assign mtip_out = mip_mtip;
    assign msip_out = mip_msip;

endmodule

// File: tb/tb_msrv32_csr_file.sv
// Directed self-checking bench for msrv32_csr_file; expected values are hand-computed.
module tb_msrv32_csr_file;

    logic        clk;
    logic        rst;
    logic        wr_en_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic [31:0] rs1_in;
    logic [4:0]  zimm_in;
    logic [31:0] pc_in;
    logic [31:0] iadder_in;
    logic        set_epc_in;
    logic        set_cause_in;
    logic        i_or_e_in;
    logic [3:0]  cause_in;
    logic        instret_inc_in;
    logic        mie_clear_in;
    logic        mie_set_in;
    logic        misaligned_exception_in;
    logic        e_irq_in;
    logic        t_irq_in;
    logic        s_irq_in;
    logic [31:0] csr_data_out;
    logic [31:0] epc_out;
    logic [31:0] trap_address_out;
    logic        mie_out;
    logic        meie_out;
    logic        mtie_out;
    logic        msie_out;
    logic        meip_out;
    logic        mtip_out;
    logic        msip_out;
    logic        illegal_csr_out;

    int checks = 0;
    int fails  = 0;

    msrv32_csr_file dut (
        .ms_riscv32_mp_clk_in    (clk),
        .ms_riscv32_mp_rst_in    (rst),
        .wr_en_in                (wr_en_in),
        .csr_addr_in             (csr_addr_in),
        .csr_op_in               (csr_op_in),
        .rs1_in                  (rs1_in),
        .zimm_in                 (zimm_in),
        .pc_in                   (pc_in),
        .iadder_in               (iadder_in),
        .set_epc_in              (set_epc_in),
        .set_cause_in            (set_cause_in),
        .i_or_e_in               (i_or_e_in),
        .cause_in                (cause_in),
        .instret_inc_in          (instret_inc_in),
        .mie_clear_in            (mie_clear_in),
        .mie_set_in              (mie_set_in),
        .misaligned_exception_in (misaligned_exception_in),
        .e_irq_in                (e_irq_in),
        .t_irq_in                (t_irq_in),
        .s_irq_in                (s_irq_in),
        .csr_data_out            (csr_data_out),
        .epc_out                 (epc_out),
        .trap_address_out        (trap_address_out),
        .mie_out                 (mie_out),
        .meie_out                (meie_out),
        .mtie_out                (mtie_out),
        .msie_out                (msie_out),
        .meip_out                (meip_out),
        .mtip_out                (mtip_out),
        .msip_out                (msip_out),
        .illegal_csr_out         (illegal_csr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en_in = 0; csr_addr_in = '0; csr_op_in = '0; rs1_in = '0; zimm_in = '0;
        pc_in = '0; iadder_in = '0; set_epc_in = 0; set_cause_in = 0; i_or_e_in = 0;
        cause_in = '0; instret_inc_in = 0; mie_clear_in = 0; mie_set_in = 0;
        misaligned_exception_in = 0; e_irq_in = 0; t_irq_in = 0; s_irq_in = 0;
    endtask

    task automatic csr_cmd(input logic [11:0] addr, input logic [2:0] op,
                           input logic [31:0] rs1, input logic [4:0] zimm);
        wr_en_in = 1; csr_addr_in = addr; csr_op_in = op; rs1_in = rs1; zimm_in = zimm;
    endtask

    task automatic peek(input logic [11:0] addr, output logic [31:0] data);
        wr_en_in = 0;
        csr_addr_in = addr;
        #1;
        data = csr_data_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        clear_inputs();
        rst = 1;
        csr_cmd(12'h340, 3'b001, 32'hFFFF_FFFF, 5'd0);
        set_epc_in = 1; pc_in = 32'h0000_0444; instret_inc_in = 1; mie_set_in = 1;
        tick(); tick();
        clear_inputs();
        peek(12'hB00, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mcycle actual=%h required=%h", d, 32'h0); end
        rst = 0;
        peek(12'h340, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mscratch actual=%h required=%h", d, 32'h0); end
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1800) begin fails++; $display("FAIL reset_mstatus actual=%h required=%h", d, 32'h0000_1800); end
        peek(12'h301, d);
        checks++; if (d !== 32'h4000_0100) begin fails++; $display("FAIL reset_misa actual=%h required=%h", d, 32'h4000_0100); end
        peek(12'h305, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mtvec actual=%h required=%h", d, 32'h0); end
        checks++; if (epc_out !== 32'h0) begin fails++; $display("FAIL reset_epc actual=%h required=%h", epc_out, 32'h0); end
        peek(12'hB02, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_minstret actual=%h required=%h", d, 32'h0); end
        checks++; if ({mie_out, meie_out, mtie_out, msie_out, illegal_csr_out} !== 5'b0)
            begin fails++; $display("FAIL reset_flags actual=%b required=%b", {mie_out, meie_out, mtie_out, msie_out, illegal_csr_out}, 5'b0); end
    endtask

    task automatic test_mtvec();
        logic [31:0] d;
        tick();
        csr_cmd(12'h305, 3'b001, 32'h0000_1001, 5'd0);
        #1;
        checks++; if (illegal_csr_out !== 1'b0) begin fails++; $display("FAIL mtvec_legal actual=%b required=%b", illegal_csr_out, 1'b0); end
        tick();
        clear_inputs();
        peek(12'h305, d);
        checks++; if (d !== 32'h0000_1001) begin fails++; $display("FAIL mtvec_read actual=%h required=%h", d, 32'h0000_1001); end
        checks++; if (trap_address_out !== 32'h0000_1000) begin fails++; $display("FAIL mtvec_trap_addr actual=%h required=%h", trap_address_out, 32'h0000_1000); end
        // bit 1 is hardwired to zero
        csr_cmd(12'h305, 3'b001, 32'h0000_2003, 5'd0);
        tick();
        clear_inputs();
        peek(12'h305, d);
        checks++; if (d !== 32'h0000_2001) begin fails++; $display("FAIL mtvec_bit1 actual=%h required=%h", d, 32'h0000_2001); end
        csr_cmd(12'h305, 3'b001, 32'h0000_1001, 5'd0);
        tick();
        clear_inputs();
    endtask

    task automatic test_trap_cause();
        logic [31:0] d;
        set_cause_in = 1; i_or_e_in = 1; cause_in = 4'd7; iadder_in = 32'h0000_FFFF;
        tick();
        clear_inputs();
        peek(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin fails++; $display("FAIL cause_irq actual=%h required=%h", d, 32'h8000_0007); end
        checks++; if (trap_address_out !== 32'h0000_101C) begin fails++; $display("FAIL vectored_addr actual=%h required=%h", trap_address_out, 32'h0000_101C); end
        peek(12'h343, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL mtval_zero actual=%h required=%h", d, 32'h0); end
        // exception with misaligned address and a competing mcause write
        csr_cmd(12'h342, 3'b001, 32'h0000_DEAD, 5'd0);
        set_cause_in = 1; i_or_e_in = 0; cause_in = 4'd4;
        misaligned_exception_in = 1; iadder_in = 32'h1234_5678;
        tick();
        clear_inputs();
        peek(12'h342, d);
        checks++; if (d !== 32'h0000_0004) begin fails++; $display("FAIL cause_exc_priority actual=%h required=%h", d, 32'h0000_0004); end
        peek(12'h343, d);
        checks++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL mtval_addr actual=%h required=%h", d, 32'h1234_5678); end
        checks++; if (trap_address_out !== 32'h0000_1000) begin fails++; $display("FAIL exc_base_addr actual=%h required=%h", trap_address_out, 32'h0000_1000); end
    endtask

    task automatic test_mie();
        logic [31:0] d;
        csr_cmd(12'h300, 3'b010, 32'h0000_0008, 5'd0);
        tick();
        clear_inputs();
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1808 || mie_out !== 1'b1) begin fails++; $display("FAIL mstatus_set actual=%h/%b required=%h/1", d, mie_out, 32'h0000_1808); end
        mie_clear_in = 1;
        tick();
        clear_inputs();
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1880 || mie_out !== 1'b0) begin fails++; $display("FAIL mie_clear actual=%h/%b required=%h/0", d, mie_out, 32'h0000_1880); end
        mie_set_in = 1;
        tick();
        clear_inputs();
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1888 || mie_out !== 1'b1) begin fails++; $display("FAIL mie_set actual=%h/%b required=%h/1", d, mie_out, 32'h0000_1888); end
        mie_clear_in = 1; mie_set_in = 1;
        csr_cmd(12'h300, 3'b001, 32'h0000_0008, 5'd0);
        tick();
        clear_inputs();
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1880) begin fails++; $display("FAIL mie_both actual=%h required=%h", d, 32'h0000_1880); end
        csr_cmd(12'h304, 3'b001, 32'hFFFF_FFFF, 5'd0);
        tick();
        clear_inputs();
        peek(12'h304, d);
        checks++; if (d !== 32'h0000_0888 || {meie_out, mtie_out, msie_out} !== 3'b111)
            begin fails++; $display("FAIL mie_reg_write actual=%h/%b required=%h/111", d, {meie_out, mtie_out, msie_out}, 32'h0000_0888); end
        csr_cmd(12'h304, 3'b111, 32'hFFFF_FFFF, 5'b01000);
        tick();
        clear_inputs();
        peek(12'h304, d);
        checks++; if (d !== 32'h0000_0880 || msie_out !== 1'b0) begin fails++; $display("FAIL mie_reg_rci actual=%h/%b required=%h/0", d, msie_out, 32'h0000_0880); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        e_irq_in = 1; s_irq_in = 1;
        #1;
        checks++; if (meip_out !== 1'b0) begin fails++; $display("FAIL irq_latency actual=%b required=%b", meip_out, 1'b0); end
        tick();
        checks++; if ({meip_out, mtip_out, msip_out} !== 3'b101) begin fails++; $display("FAIL irq_capture actual=%b required=%b", {meip_out, mtip_out, msip_out}, 3'b101); end
        e_irq_in = 0; s_irq_in = 0; t_irq_in = 1;
        tick();
        t_irq_in = 0;
        peek(12'h344, d);
        checks++; if (d !== 32'h0000_0080) begin fails++; $display("FAIL mip_read actual=%h required=%h", d, 32'h0000_0080); end
        tick();
    endtask

    task automatic test_counter();
        logic [31:0] d;
        csr_cmd(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0);
        tick();
        clear_inputs();
        peek(12'hB00, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mcycle_write actual=%h required=%h", d, 32'hFFFF_FFFF); end
        peek(12'hB80, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL mcycleh_before actual=%h required=%h", d, 32'h0); end
        tick();
        peek(12'hC00, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL mcycle_wrap_lo actual=%h required=%h", d, 32'h0); end
        peek(12'hB80, d);
        checks++; if (d !== 32'h1) begin fails++; $display("FAIL mcycleh_carry actual=%h required=%h", d, 32'h1); end
        instret_inc_in = 1;
        tick(); tick(); tick();
        instret_inc_in = 0;
        peek(12'hB02, d);
        checks++; if (d !== 32'h3) begin fails++; $display("FAIL minstret_count actual=%h required=%h", d, 32'h3); end
        instret_inc_in = 1;
        csr_cmd(12'hB02, 3'b001, 32'h0000_000A, 5'd0);
        tick();
        clear_inputs();
        peek(12'hC02, d);
        checks++; if (d !== 32'hA) begin fails++; $display("FAIL minstret_write_wins actual=%h required=%h", d, 32'hA); end
        csr_cmd(12'hB82, 3'b001, 32'hFFFF_FFFF, 5'd0);
        tick();
        csr_cmd(12'hB02, 3'b001, 32'hFFFF_FFFF, 5'd0);
        tick();
        clear_inputs();
        peek(12'hC82, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL minstreth_write actual=%h required=%h", d, 32'hFFFF_FFFF); end
        instret_inc_in = 1;
        tick();
        instret_inc_in = 0;
        peek(12'hB02, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL minstret_wrap_lo actual=%h required=%h", d, 32'h0); end
        peek(12'hB82, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL minstret_wrap_hi actual=%h required=%h", d, 32'h0); end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        csr_cmd(12'h301, 3'b010, 32'h0000_0001, 5'd0);
        #1;
        checks++; if (illegal_csr_out !== 1'b1) begin fails++; $display("FAIL misa_rs_illegal actual=%b required=%b", illegal_csr_out, 1'b1); end
        tick();
        clear_inputs();
        peek(12'h301, d);
        checks++; if (d !== 32'h4000_0100) begin fails++; $display("FAIL misa_unchanged actual=%h required=%h", d, 32'h4000_0100); end
        csr_cmd(12'h7C0, 3'b010, 32'h0, 5'd0);
        #1;
        checks++; if (illegal_csr_out !== 1'b1 || csr_data_out !== 32'h0)
            begin fails++; $display("FAIL unimpl_addr actual=%b/%h required=1/%h", illegal_csr_out, csr_data_out, 32'h0); end
        csr_cmd(12'hC00, 3'b010, 32'h0, 5'd0);
        #1;
        checks++; if (illegal_csr_out !== 1'b0) begin fails++; $display("FAIL cycle_read_legal actual=%b required=%b", illegal_csr_out, 1'b0); end
        csr_cmd(12'hC00, 3'b001, 32'h0, 5'd0);
        #1;
        checks++; if (illegal_csr_out !== 1'b1) begin fails++; $display("FAIL cycle_rw_illegal actual=%b required=%b", illegal_csr_out, 1'b1); end
        clear_inputs();
        #1;
        checks++; if (illegal_csr_out !== 1'b0) begin fails++; $display("FAIL illegal_idle actual=%b required=%b", illegal_csr_out, 1'b0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        tick();
        csr_cmd(12'h341, 3'b001, 32'h0000_0040, 5'd0);
        set_epc_in = 1; pc_in = 32'h0000_0200;
        tick();
        clear_inputs();
        #1;
        checks++; if (epc_out !== 32'h0000_0200) begin fails++; $display("FAIL epc_priority actual=%h required=%h", epc_out, 32'h0000_0200); end
        csr_cmd(12'h341, 3'b001, 32'h0000_0047, 5'd0);
        tick();
        clear_inputs();
        peek(12'h341, d);
        checks++; if (d !== 32'h0000_0044) begin fails++; $display("FAIL mepc_align actual=%h required=%h", d, 32'h0000_0044); end
        csr_cmd(12'h340, 3'b001, 32'hA5A5_0000, 5'd0);
        tick();
        csr_cmd(12'h340, 3'b010, 32'h0, 5'd0);
        tick();
        clear_inputs();
        peek(12'h340, d);
        checks++; if (d !== 32'hA5A5_0000) begin fails++; $display("FAIL rs_zero_suppressed actual=%h required=%h", d, 32'hA5A5_0000); end
        csr_cmd(12'h340, 3'b011, 32'hFFFF_0000, 5'd0);
        tick();
        csr_cmd(12'h340, 3'b110, 32'hFFFF_FFFF, 5'h1F);
        tick();
        clear_inputs();
        peek(12'h340, d);
        checks++; if (d !== 32'h0000_001F) begin fails++; $display("FAIL rc_then_rsi actual=%h required=%h", d, 32'h0000_001F); end
        csr_cmd(12'h340, 3'b101, 32'hFFFF_FFFF, 5'h03);
        tick();
        clear_inputs();
        peek(12'h340, d);
        checks++; if (d !== 32'h0000_0003) begin fails++; $display("FAIL rwi actual=%h required=%h", d, 32'h0000_0003); end
    endtask

    task automatic test_reset_priority();
        logic [31:0] d;
        rst = 1;
        set_epc_in = 1; pc_in = 32'h0000_0800;
        set_cause_in = 1; i_or_e_in = 1; cause_in = 4'd11;
        e_irq_in = 1; mie_set_in = 1; instret_inc_in = 1;
        tick();
        clear_inputs();
        rst = 0;
        #1;
        checks++; if (epc_out !== 32'h0 || meip_out !== 1'b0 || mie_out !== 1'b0)
            begin fails++; $display("FAIL reset_over_trap actual=%h/%b/%b required=0/0/0", epc_out, meip_out, mie_out); end
        peek(12'h342, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mcause actual=%h required=%h", d, 32'h0); end
        checks++; if (trap_address_out !== 32'h0) begin fails++; $display("FAIL reset_trap_addr actual=%h required=%h", trap_address_out, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_mtvec();
        test_trap_cause();
        test_mie();
        test_irq();
        test_counter();
        test_illegal();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
